trigger_sequencer: RTL
======================

// Module: trigger_sequencer
// PURPOSE
//  Consumes the registered per-matcher event bits (sts_evt) of the trigger matchers and turns them
//  into one capture trigger. A STG-stage FSM: each stage waits for a programmed count of hits on a
//  masked OR of matcher events, then advances. After the last stage, a post-trigger delay counts
//  sample transfers, then sts_trg pulses. The capture controller consumes sts_trg.
// PARAMETERS
//  MTN  4   number of matcher event inputs
//  STG  4   number of sequencer stages (>=2)
//  CNW  16  per-stage occurrence counter width
//  DLW  16  post-trigger delay counter width
// PORTS
//  clk           in   1          clock
//  rst           in   1          reset, asynchronous, active-high
//  ctl_arm       in   1          pulse: start/restart at stage 0
//  ctl_abort     in   1          pulse: return to IDLE
//  cfg_msk       in   STG*MTN    stage k event mask, bits [k*MTN +: MTN]
//  cfg_cnt       in   STG*CNW    stage k required hits minus 1, bits [k*CNW +: CNW]
//  cfg_lst       in   STG        stage k is final stage
//  cfg_dly       in   DLW        post-trigger delay, in sti_transfer cycles
//  cfg_tmo       in   CNW        stage timeout, in transfers (used only with macro)
//  sti_transfer  in   1          sample transfer qualifier, same as the matchers'
//  evt           in   MTN        matcher sts_evt bits, registered, valid on transfer cycles
//  sts_armed     out  1          FSM in STAGE or DELAY
//  sts_stage     out  $clog2(STG) current stage index
//  sts_trg       out  1          one-clk trigger pulse
//  sts_tmo       out  1          one-clk timeout pulse (0 without macro)
// BEHAVIOUR
//  - Reset: state IDLE; sts_armed=0, sts_stage=0, sts_trg=0, sts_tmo=0; counters 0.
//  - States: IDLE, STAGE, DELAY, FIRED. All outputs registered.
//  - Priority per clk: ctl_abort > ctl_arm > event processing. Abort -> IDLE, counters cleared.
//  - ctl_arm in any state -> STAGE, stage=0, hit counter=0. Event processing is skipped that cycle.
//  - Events are evaluated only when sti_transfer=1. hit = |(evt & cfg_msk[k]).
//    A stage with msk=0 never hits.
//  - STAGE k, hit and hit counter==cfg_cnt[k]: stage done. Otherwise hit -> counter+1.
//    Counter has CNW bits. cnt=0 means the first hit completes the stage.
//  - Stage done, not final -> stage k+1, counter=0. Final = cfg_lst[k] | (k==STG-1).
//  - Final stage done with cfg_dly==0 -> sts_trg=1 on the next clk; state FIRED.
//  - Final stage done with cfg_dly!=0 -> DELAY, delay counter=0.
//  - DELAY: each sti_transfer increments the delay counter. When the counter reaches cfg_dly:
//    sts_trg=1 on the next clk; state FIRED.
//  - Transfers in DELAY ignore evt.
//  - FIRED: sts_trg exactly 1 clk; holds until ctl_arm/ctl_abort. Never re-triggers by itself.
//  - Latency: hit on transfer cycle t -> sts_stage/state updated at t+1.
//  - Cfg changes while armed take effect on the next evaluation. No shadowing.
// CONFIGURATION
//  - Macro TRIGGER_SEQUENCER_TIMEOUT_EN defined:
//    - A per-stage timeout counter counts transfers in STAGE with no stage advance.
//    - On reaching cfg_tmo (cfg_tmo!=0): stage=0, counters=0, sts_tmo pulses 1 clk.
//    - On that same transfer, a stage completion takes priority over the timeout.
//    - The timeout does not run in stage 0 or DELAY.
//  - Macro not defined: no timeout logic, cfg_tmo ignored, sts_tmo tied 0.
// TESTING
//  1 rst mid-DELAY -> all outputs 0 asynchronously; after release, IDLE, evt ignored until ctl_arm.
//  2 Single stage: arm, msk0=4'b0001, cnt0=0, lst0=1, dly=0; evt[0]=1 on a transfer at cycle t
//    -> sts_trg=1 at t+1 only.
//  3 Two stages: msk0=0001 cnt0=2, msk1=0100 cnt1=0, lst1=1, dly=3.
//    - 3 evt[0] hits -> stage 1.
//    - evt[2] hit -> DELAY.
//    - sts_trg one clk after the 3rd following transfer.
//    - evt[2] during stage 0 is ignored.
//  4 Non-transfer gating: evt=1111 with sti_transfer=0 for 10 clks -> no stage or count change.
//  5 Priority: ctl_arm and ctl_abort same clk while in stage 2 -> IDLE.
//    ctl_arm alone in FIRED -> STAGE, stage 0, sts_trg stays 0.
//  6 With TRIGGER_SEQUENCER_TIMEOUT_EN, cfg_tmo=5, stall in stage 1
//    -> sts_tmo pulse after the 5th transfer, sts_stage=0. Without the macro, sts_tmo stays 0.

Source files
------------

// File: rtl/trigger_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// trigger_sequencer
// Multi-stage trigger sequencer. Each stage waits for a programmed number of
// hits on a masked OR of the matcher event bits, then advances. Once the final
// stage completes, an optional post-trigger delay counts sample transfers
// before a single-clock trigger pulse is issued to the capture controller.
//
// Optional feature: define TRIGGER_SEQUENCER_TIMEOUT_EN to add a per-stage
// timeout that returns a stalled sequence (stage > 0) to stage 0 and pulses
// sts_tmo. Without the macro cfg_tmo is ignored and sts_tmo is tied low.
// -----------------------------------------------------------------------------
module trigger_sequencer #(
    parameter int MTN = 4,   // matcher event inputs
    parameter int STG = 4,   // sequencer stages (>= 2)
    parameter int CNW = 16,  // per-stage occurrence counter width
    parameter int DLW = 16   // post-trigger delay counter width
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctl_arm,
    input  logic                   ctl_abort,
    input  logic [STG*MTN-1:0]     cfg_msk,
    input  logic [STG*CNW-1:0]     cfg_cnt,
    input  logic [STG-1:0]         cfg_lst,
    input  logic [DLW-1:0]         cfg_dly,
    input  logic [CNW-1:0]         cfg_tmo,
    input  logic                   sti_transfer,
    input  logic [MTN-1:0]         evt,
    output logic                   sts_armed,
    output logic [$clog2(STG)-1:0] sts_stage,
    output logic                   sts_trg,
    output logic                   sts_tmo
);

    localparam int SW = $clog2(STG);

    // Sequencer states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STAGE = 2'd1;
    localparam logic [1:0] S_DELAY = 2'd2;
    localparam logic [1:0] S_FIRED = 2'd3;

    localparam logic [SW-1:0] LAST_STAGE = SW'(STG - 1);

    // Registered state
    logic [1:0]     state;
    logic [SW-1:0]  stage;
    logic [CNW-1:0] hit_cnt;
    logic [DLW-1:0] dly_cnt;
    logic           armed;
    logic           trg;
    logic           tmo;

    // Next-state values
    logic [1:0]     state_nxt;
    logic [SW-1:0]  stage_nxt;
    logic [CNW-1:0] hit_cnt_nxt;
    logic [DLW-1:0] dly_cnt_nxt;
    logic           trg_nxt;
    logic           tmo_nxt;

    // Configuration of the stage currently being evaluated
    logic [MTN-1:0] cur_msk;
    logic [CNW-1:0] cur_cnt;
    logic           cur_lst;
    logic           hit;
    logic           stage_done;
    logic           is_final;
    logic [DLW:0]   dly_inc;
    logic           dly_reached;

`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
    logic [CNW-1:0] tmo_cnt;
    logic [CNW-1:0] tmo_cnt_nxt;
    logic [CNW:0]   tmo_inc;
    logic           tmo_reached;
`else
    // cfg_tmo has no function in this build; fold it into a sink net.
    logic unused_tmo;
    assign unused_tmo = ^cfg_tmo;
`endif

    // Select the active stage's mask/count/final flag and evaluate the hit.
    // The configuration is read live, so changes while armed apply on the
    // very next evaluation.
    always_comb begin
        cur_msk     = cfg_msk[stage*MTN +: MTN];
        cur_cnt     = cfg_cnt[stage*CNW +: CNW];
        cur_lst     = cfg_lst[stage];
        hit         = |(evt & cur_msk);
        stage_done  = sti_transfer && hit && (hit_cnt == cur_cnt);
        is_final    = cur_lst || (stage == LAST_STAGE);
        // One extra bit keeps the compare free of wrap-around.
        dly_inc     = {1'b0, dly_cnt} + {{DLW{1'b0}}, 1'b1};
        dly_reached = dly_inc >= {1'b0, cfg_dly};
    end

`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
    // Timeout threshold: a zero cfg_tmo disables the timeout.
    always_comb begin
        tmo_inc     = {1'b0, tmo_cnt} + {{CNW{1'b0}}, 1'b1};
        tmo_reached = (cfg_tmo != '0) && (tmo_inc >= {1'b0, cfg_tmo});
    end
`endif

    // Next-state logic: abort beats arm, arm beats event processing.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one
        // unassigned; a missing default would infer a latch.
        state_nxt   = state;
        stage_nxt   = stage;
        hit_cnt_nxt = hit_cnt;
        dly_cnt_nxt = dly_cnt;
        trg_nxt     = 1'b0;
        tmo_nxt     = 1'b0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
        tmo_cnt_nxt = tmo_cnt;
`endif

        if (ctl_abort) begin
            state_nxt   = S_IDLE;
            stage_nxt   = '0;
            hit_cnt_nxt = '0;
            dly_cnt_nxt = '0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
            tmo_cnt_nxt = '0;
`endif
        end else if (ctl_arm) begin
            // Arm restarts the sequence from any state; events on this clock
            // are deliberately not evaluated.
            state_nxt   = S_STAGE;
            stage_nxt   = '0;
            hit_cnt_nxt = '0;
            dly_cnt_nxt = '0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
            tmo_cnt_nxt = '0;
`endif
        end else if (sti_transfer) begin
            case (state)
                S_STAGE: begin
                    if (stage_done) begin
                        hit_cnt_nxt = '0;
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
                        // Completion wins over a timeout on the same transfer.
                        tmo_cnt_nxt = '0;
`endif
                        if (is_final) begin
                            if (cfg_dly == '0) begin
                                state_nxt = S_FIRED;
                                trg_nxt   = 1'b1;
                            end else begin
                                state_nxt   = S_DELAY;
                                dly_cnt_nxt = '0;
                            end
                        end else begin
                            stage_nxt = stage + SW'(1);
                        end
                    end else begin
                        if (hit) begin
                            hit_cnt_nxt = hit_cnt + CNW'(1);
                        end
`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
                        // Stage 0 waits indefinitely; later stages may time out.
                        if (stage != '0) begin
                            if (tmo_reached) begin
                                stage_nxt   = '0;
                                hit_cnt_nxt = '0;
                                tmo_cnt_nxt = '0;
                                tmo_nxt     = 1'b1;
                            end else begin
                                tmo_cnt_nxt = tmo_inc[CNW-1:0];
                            end
                        end
`endif
                    end
                end
                S_DELAY: begin
                    // Events are irrelevant here; only transfers are counted.
                    if (dly_reached) begin
                        state_nxt = S_FIRED;
                        trg_nxt   = 1'b1;
                    end else begin
                        dly_cnt_nxt = dly_inc[DLW-1:0];
                    end
                end
                default: begin
                    // IDLE and FIRED ignore events; FIRED never re-triggers.
                end
            endcase
        end
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            stage   <= '0;
            hit_cnt <= '0;
            dly_cnt <= '0;
            armed   <= 1'b0;
            trg     <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state   <= state_nxt;
            stage   <= stage_nxt;
            hit_cnt <= hit_cnt_nxt;
            dly_cnt <= dly_cnt_nxt;
            armed   <= (state_nxt == S_STAGE) || (state_nxt == S_DELAY);
            trg     <= trg_nxt;
            tmo     <= tmo_nxt;
        end
    end

`ifdef TRIGGER_SEQUENCER_TIMEOUT_EN
    // Per-stage timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt_nxt;
        end
    end
`endif

    // The stage index is held through DELAY and FIRED so software can see
    // which stage completed the sequence.
    assign sts_armed = armed;
    assign sts_stage = stage;
    assign sts_trg   = trg;
    assign sts_tmo   = tmo;

endmodule
